// File: rtl/dmem_arbiter.sv
// Two-master (CPU / DMA) arbiter for a single-ported data memory: IDLE -> ACCESS -> RESP per transaction.
// Optional round-robin arbitration on simultaneous requests: define DMEM_ARB_ROUND_ROBIN_EN.
module dmem_arbiter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_done_o,
  output logic        cpu_stall_o,
  input  logic        dma_req_i,
  input  logic        dma_we_i,
  input  logic [31:0] dma_addr_i,
  input  logic [31:0] dma_wdata_i,
  output logic [31:0] dma_rdata_o,
  output logic        dma_done_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  input  logic [31:0] mem_data_i
);

  // Handshake: a requester raises req with we/addr/wdata and holds req until its
  // done pulses for one cycle; fields are sampled only at the granting IDLE edge,
  // and a req still high during RESP is arbitrated again as a new transaction.

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        gnt_dma_q, gnt_dma_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        any_req;
  logic        pick_dma;

  assign any_req = cpu_req_i | dma_req_i;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic last_dma_q, last_dma_d;

  // On contention, serve whichever master was not granted last.
  always_comb begin
    pick_dma = dma_req_i & (~cpu_req_i | ~last_dma_q);
  end

  always_comb begin
    last_dma_d = last_dma_q;
    if (state_q == ST_IDLE && any_req) begin
      last_dma_d = pick_dma;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_dma_q <= 1'b1;
    end else begin
      last_dma_q <= last_dma_d;
    end
  end
`else
  always_comb begin
    pick_dma = dma_req_i & ~cpu_req_i;
  end
`endif

  always_comb begin
    state_d   = state_q;
    gnt_dma_d = gnt_dma_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          gnt_dma_d = pick_dma;
          we_d      = pick_dma ? dma_we_i    : cpu_we_i;
          addr_d    = pick_dma ? dma_addr_i  : cpu_addr_i;
          wdata_d   = pick_dma ? dma_wdata_i : cpu_wdata_i;
          state_d   = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!we_q) begin
          rdata_d = mem_data_i;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      gnt_dma_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      rdata_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      gnt_dma_q <= gnt_dma_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
    end
  end

  // Outputs decode straight from registered state so an async reset drops them at once.
  always_comb begin
    mem_addr_o  = addr_q;
    mem_wdata_o = wdata_q;
    mem_read_o  = (state_q == ST_ACCESS) & ~we_q;
    mem_write_o = (state_q == ST_ACCESS) &  we_q;
    cpu_done_o  = (state_q == ST_RESP) & ~gnt_dma_q;
    dma_done_o  = (state_q == ST_RESP) &  gnt_dma_q;
    cpu_rdata_o = cpu_done_o ? rdata_q : 32'h0;
    dma_rdata_o = dma_done_o ? rdata_q : 32'h0;
    // Stall is masked during reset so every output reads 0 while rst_i is high.
    cpu_stall_o = cpu_req_i & ~cpu_done_o & ~rst_i;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- cpu_req_i  in  1  CPU MEM-stage request, held until cpu_done_o.
- cpu_we_i  in  1  1 = store, 0 = load.
- cpu_addr_i  in  32  CPU byte address.
- cpu_wdata_i  in  32  CPU store data.
- cpu_rdata_o  out  32  CPU load data, valid while cpu_done_o = 1.
- cpu_done_o  out  1  one-cycle completion pulse to CPU.
- cpu_stall_o  out  1  pipeline stall.
- dma_req_i  in  1  DMA/debug request, held until dma_done_o.
- dma_we_i  in  1  1 = write, 0 = read.
- dma_addr_i  in  32  DMA byte address.
- dma_wdata_i  in  32  DMA write data.
- dma_rdata_o  out  32  DMA read data, valid while dma_done_o = 1.
- dma_done_o  out  1  one-cycle completion pulse to DMA.
- mem_addr_o  out  32  data-memory address.
- mem_wdata_o  out  32  data-memory write data.
- mem_read_o  out  1  data-memory read enable.
- mem_write_o  out  1  data-memory write enable.
- mem_data_i  in  32  data-memory read data, combinational from mem_addr_o.
REQ-002 SHALL use one clock (clk_i) and an asynchronous, active-high reset (rst_i).

Function
REQ-003 SHALL implement the FSM states IDLE, ACCESS and RESP.
REQ-004 IDLE: if any request is high at a rising edge, SHALL latch the winner's id, we, addr and wdata, then enter ACCESS; otherwise SHALL stay in IDLE.
REQ-005 ACCESS (exactly one cycle): SHALL drive mem_addr_o and mem_wdata_o from the latched values and assert exactly one of mem_read_o (we=0) or mem_write_o (we=1), then enter RESP.
REQ-006 At the rising edge ending ACCESS, a load SHALL capture mem_data_i into the read register; a store SHALL leave that register unchanged.
REQ-007 RESP: SHALL pulse only the winner's done_o for one cycle, then enter IDLE.
REQ-008 The winner's rdata_o SHALL equal the read register during RESP; both rdata_o outputs SHALL be 0 otherwise.
REQ-009 Latency: a request sampled at edge k SHALL drive ACCESS in cycle k+1 and done in cycle k+2. Each transaction SHALL take 3 cycles, minimum 3 cycles between grants.
REQ-010 Outside ACCESS, mem_read_o and mem_write_o SHALL be 0; mem_addr_o and mem_wdata_o SHALL hold their last latched values.
REQ-011 cpu_stall_o SHALL equal cpu_req_i AND NOT cpu_done_o (combinational).
REQ-012 Dropping a request after it is latched SHALL NOT abort the transaction; it SHALL complete and pulse done.
REQ-013 Changing addr, wdata or we after latching SHALL have no effect on the transaction in flight.
REQ-014 A request still high during RESP SHALL be re-arbitrated in the following IDLE cycle as a new transaction.
REQ-015 A request from the non-winner SHALL wait with no done and no memory access.
REQ-016 Simultaneous requests in IDLE SHALL be resolved by the arbitration policy of REQ-020/REQ-021.

Reset
REQ-017 While rst_i = 1, SHALL hold: state IDLE, all outputs 0, read register 0, last-grant register = DMA.
REQ-018 Reset in ACCESS SHALL drop mem_write_o/mem_read_o immediately. The transaction SHALL be discarded with no done pulse, and the requester SHALL reissue it.
REQ-019 After rst_i deasserts, the first rising edge SHALL be treated as IDLE arbitration.

Configuration
REQ-020 With DMEM_ARB_ROUND_ROBIN_EN defined, on simultaneous requests the arbiter SHALL grant the requester not served last, and SHALL update the last-grant register on every grant.
REQ-021 Without DMEM_ARB_ROUND_ROBIN_EN, the CPU SHALL always win simultaneous requests; the last-grant register SHALL be absent.

Verification
REQ-022 CPU store addr 0x8, data 0xDEADBEEF -> mem_write_o=1 for exactly one cycle at 0x8; cpu_done_o two cycles after the request edge; cpu_stall_o high for 2 cycles.
REQ-023 CPU load addr 0x8 after REQ-022 -> mem_read_o one cycle; cpu_rdata_o=0xDEADBEEF with cpu_done_o; dma_rdata_o=0.
REQ-024 Both requesters held high from reset, CPU load 0x0, DMA load 0x4 -> with macro: grants alternate CPU, DMA, CPU; without macro: CPU only, dma_done_o never pulses.
REQ-025 DMA write 0x10, data 0x12345678, dma_req_i dropped in cycle k+1 -> write still performed, dma_done_o pulses in cycle k+2.
REQ-026 rst_i asserted mid-ACCESS of CPU store 0x14 -> mem_write_o falls asynchronously, no cpu_done_o, all outputs 0; FSM in IDLE on release.
